// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : div_arbiter
// Description : Round-robin arbiter sharing one divider between two
//               requesters, with divide-by-zero bypass and a done timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module div_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_a,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] dividend_a,
    input  logic [WIDTH-1:0] dividend_b,
    input  logic [WIDTH-1:0] divisor_a,
    input  logic [WIDTH-1:0] divisor_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_overflow,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [WIDTH-1:0] div_dividen,
    output logic [WIDTH-1:0] div_divisor,
    output logic             div_start,
    input  logic             div_done,
    input  logic             div_overflow,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    localparam int                c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        ZERO  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_last_grant;
    logic                 r_id;
    logic [c_cnt_w-1:0]   r_wait;
    logic                 r_busy;
    logic                 r_div_start;
    logic [WIDTH-1:0]     r_div_dividen;
    logic [WIDTH-1:0]     r_div_divisor;
    logic                 r_rsp_valid;
    logic                 r_rsp_id;
    logic [WIDTH-1:0]     r_rsp_quotient;
    logic [WIDTH-1:0]     r_rsp_remainder;
    logic                 r_rsp_overflow;
    logic                 r_rsp_timeout;

    logic                 w_gnt_any;
    logic                 w_gnt_b;
    logic [WIDTH-1:0]     w_sel_dividend;
    logic [WIDTH-1:0]     w_sel_divisor;
    logic                 w_grant_now;

    // On a tie the requester not served last wins; otherwise whoever asks.
    always_comb begin
        w_gnt_any = req_a | req_b;
        w_gnt_b   = 1'b0;
        if (req_a && req_b) begin
            w_gnt_b = ~r_last_grant;
        end else begin
            w_gnt_b = req_b;
        end
        w_sel_dividend = w_gnt_b ? dividend_b : dividend_a;
        w_sel_divisor  = w_gnt_b ? divisor_b  : divisor_a;
    end

    // Acceptance is signalled in the IDLE cycle whose edge takes the grant.
    assign w_grant_now = (r_state == IDLE) && reset_a && w_gnt_any;
    assign ack_a       = w_grant_now && !w_gnt_b;
    assign ack_b       = w_grant_now &&  w_gnt_b;

    always_ff @(posedge clk) begin
        if (!reset_a) begin
            r_state         <= IDLE;
            r_last_grant    <= 1'b1;
            r_id            <= 1'b0;
            r_wait          <= '0;
            r_busy          <= 1'b0;
            r_div_start     <= 1'b0;
            r_div_dividen   <= '0;
            r_div_divisor   <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= 1'b0;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_timeout   <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_last_grant  <= w_gnt_b;
                        r_id          <= w_gnt_b;
                        r_div_dividen <= w_sel_dividend;
                        r_div_divisor <= w_sel_divisor;
                        r_busy        <= 1'b1;
                        if (w_sel_divisor == '0) begin
                            r_state <= ZERO;
                        end else begin
                            r_state     <= START;
                            r_div_start <= 1'b1;
                        end
                    end
                end
                START: begin
                    r_wait  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the last wait cycle beats the timeout.
                    if (div_done) begin
                        r_rsp_quotient  <= div_quotient;
                        r_rsp_remainder <= div_remainder;
                        r_rsp_overflow  <= div_overflow;
                        r_rsp_timeout   <= 1'b0;
                        r_rsp_id        <= r_id;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RESP;
                    end else if (r_wait == c_wait_last) begin
                        r_rsp_quotient  <= '0;
                        r_rsp_remainder <= '0;
                        r_rsp_overflow  <= 1'b0;
                        r_rsp_timeout   <= 1'b1;
                        r_rsp_id        <= r_id;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RESP;
                    end else begin
                        r_wait <= r_wait + c_cnt_w'(1);
                    end
                end
                ZERO: begin
                    r_rsp_quotient  <= '1;
                    r_rsp_remainder <= r_div_dividen;
                    r_rsp_overflow  <= 1'b1;
                    r_rsp_timeout   <= 1'b0;
                    r_rsp_id        <= r_id;
                    r_rsp_valid     <= 1'b1;
                    r_state         <= RESP;
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign div_start     = r_div_start;
    assign div_dividen   = r_div_dividen;
    assign div_divisor   = r_div_divisor;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_overflow  = r_rsp_overflow;
    assign rsp_timeout   = r_rsp_timeout;

endmodule
`default_nettype wire
